// File: rtl/moving_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : moving_avg_pkg
// Description : Shared types and constants for the moving-average datapath.
//               Holds the inverse-filter accumulator width function, the
//               priming/run state encoding and the saturation counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package moving_avg_pkg;

    localparam int SAT_CNT_W = 16;

    typedef enum logic [0:0] {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Sign-extended difference needs WIDTH+1 bits, the shift adds K, and adding
    // y_prev back adds one more, so WIDTH+K+2 bits can never wrap.
    function automatic int calc_accw(input int width, input int k);
        return width + k + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_clip.sv
`default_nettype none
// ============================================================================
// Module      : sat_clip
// Description : Combinational signed saturation of an IN_W-bit value into
//               OUT_W bits, with a flag raised whenever clipping occurred.
// Ports       : i_val     - signed input, IN_W bits
//               o_val     - saturated result, OUT_W bits
//               o_clipped - high when i_val was outside the OUT_W range
// Revision    : 1.0 - initial release
// ============================================================================
module sat_clip #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_val,
    output logic [OUT_W-1:0] o_val,
    output logic             o_clipped
);

    // The value fits when every bit from the OUT_W sign bit upward is equal.
    logic [IN_W-OUT_W:0] w_top;
    logic                w_fits;

    assign w_top  = i_val[IN_W-1:OUT_W-1];
    assign w_fits = (&w_top) | ~(|w_top);

    always_comb begin
        o_clipped = ~w_fits;
        o_val     = i_val[OUT_W-1:0];
        if (!w_fits) begin
            if (i_val[IN_W-1]) begin
                o_val = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                o_val = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ema_inverse_filter.sv
`default_nettype none
// ============================================================================
// Module      : ema_inverse_filter
// Description : Undoes a 1/2^K exponential moving average:
//               x_hat[n] = y[n-1] + ((y[n] - y[n-1]) <<< K), saturated.
//               Two-stage global-stall pipeline with ready/valid handshakes.
// Ports       : clk, rst_n (async, active low), clr (sync restart)
//               in_valid/in_ready/in_sample    - smoothed input stream
//               out_valid/out_ready/out_sample - reconstructed output stream
//               sat_flag  - sticky saturation indicator
//               sat_count - saturation events, stops at all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module ema_inverse_filter
    import moving_avg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int K     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_sample,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sample,
    output logic                 sat_flag,
    output logic [SAT_CNT_W-1:0] sat_count
);

    localparam int c_ACCW = calc_accw(WIDTH, K);
    localparam int c_EXT  = c_ACCW - WIDTH;

    state_t               r_state;
    logic [WIDTH-1:0]     r_y_prev;
    logic                 r_s1_valid;
    logic [c_ACCW-1:0]    r_s1_shift;
    logic [WIDTH-1:0]     r_s1_prev;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_sample;
    logic                 r_sat_flag;
    logic [SAT_CNT_W-1:0] r_sat_count;

    logic                     w_adv;
    logic                     w_accept;
    logic signed [c_ACCW-1:0] w_y_ext;
    logic signed [c_ACCW-1:0] w_prev_ext;
    logic signed [c_ACCW-1:0] w_diff;
    logic signed [c_ACCW-1:0] w_shift;
    logic signed [c_ACCW-1:0] w_sum;
    logic [WIDTH-1:0]         w_clip_val;
    logic                     w_clipped;

    // Whole pipeline moves together; out_ready reaches in_ready combinationally.
    assign w_adv    = ~r_out_valid | out_ready;
    assign in_ready = w_adv & ~clr;
    assign w_accept = in_valid & in_ready;

    assign w_y_ext    = {{c_EXT{in_sample[WIDTH-1]}}, in_sample};
    assign w_prev_ext = {{c_EXT{r_y_prev[WIDTH-1]}}, r_y_prev};
    assign w_diff     = w_y_ext - w_prev_ext;
    assign w_shift    = w_diff <<< K;
    assign w_sum      = {{c_EXT{r_s1_prev[WIDTH-1]}}, r_s1_prev} + r_s1_shift;

    // Stage 1 and the priming FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= PRIME;
            r_y_prev   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_shift <= '0;
            r_s1_prev  <= '0;
        end else if (clr) begin
            r_state    <= PRIME;
            r_y_prev   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_shift <= '0;
            r_s1_prev  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                if (r_state == PRIME) begin
                    // No history yet: zero difference makes x_hat equal y.
                    r_s1_shift <= '0;
                    r_s1_prev  <= in_sample;
                end else begin
                    r_s1_shift <= w_shift;
                    r_s1_prev  <= r_y_prev;
                end
                r_y_prev <= in_sample;
                r_state  <= RUN;
            end
        end
    end

    sat_clip #(
        .IN_W  (c_ACCW),
        .OUT_W (WIDTH)
    ) u_sat_clip (
        .i_val     (w_sum),
        .o_val     (w_clip_val),
        .o_clipped (w_clipped)
    );

    // Stage 2: output register and saturation statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_sample <= '0;
            r_sat_flag   <= 1'b0;
            r_sat_count  <= '0;
        end else if (clr) begin
            r_out_valid  <= 1'b0;
            r_out_sample <= '0;
            r_sat_flag   <= 1'b0;
            r_sat_count  <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_sample <= w_clip_val;
                if (w_clipped) begin
                    r_sat_flag <= 1'b1;
                    if (r_sat_count != {SAT_CNT_W{1'b1}}) begin
                        r_sat_count <= r_sat_count + SAT_CNT_W'(1);
                    end
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_sample = r_out_sample;
    assign sat_flag   = r_sat_flag;
    assign sat_count  = r_sat_count;

endmodule
`default_nettype wire
